// File: rtl/agc_cdu_interface.sv
// AGC-side CDU link: CLOCKH generator, moding discretes, zero sequencer and
// +/- dtheta angle counter.

// Two-flop synchroniser plus rising-edge detect for one CDU pulse line.
module agc_cdu_pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic evt
);
  // sync_pipe[0..1] resynchronise, sync_pipe[2] holds the previous level
  logic [2:0] sync_pipe;

  // shift the async line through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[1:0], din};
  end

  assign evt = sync_pipe[1] & ~sync_pipe[2];
endmodule

module agc_cdu_interface #(
  parameter int CLK_DIV      = 977,
  parameter int CLK_HIGH     = 830,
  parameter int ZERO_PERIODS = 64,
  parameter int SETTLE_PER   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        zero_req,
  input  logic        ca_en,
  input  logic        eec_en,
  input  logic        CDUPLS,
  input  logic        CDUMNS,
  output logic        CLOCKH,
  output logic        AGCCA,
  output logic        AGCZ,
  output logic        AGCEEC,
  output logic [14:0] angle,
  output logic        busy,
  output logic        wrap
);
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PMAX = (ZERO_PERIODS > SETTLE_PER) ? ZERO_PERIODS : SETTLE_PER;
  localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HIGH_START = DW'(CLK_DIV - CLK_HIGH);
  localparam logic [CW-1:0] ZERO_LAST  = CW'(ZERO_PERIODS - 1);
  localparam logic [CW-1:0] SETL_LAST  = CW'(SETTLE_PER - 1);

  typedef enum logic [1:0] {IDLE, ZERO, SETTLE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   div;
  logic            ph;
  logic [1:0]      pin, evt;
  logic            inc, dec;

  // ---------------- CLOCKH divider ----------------
  assign ph = (div == DIV_LAST);

  // free-running period divider; CLOCKH registered from the current count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      CLOCKH <= 1'b0;
    end else begin
      div    <= ph ? '0 : div + 1'b1;
      CLOCKH <= (div >= HIGH_START);
    end
  end

  // discretes only move on period boundaries so the CDU sees clean edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AGCCA  <= 1'b0;
      AGCEEC <= 1'b0;
    end else if (ph) begin
      AGCCA  <= ca_en;
      AGCEEC <= eec_en;
    end
  end

  // ---------------- pulse inputs ----------------
  assign pin = {CDUMNS, CDUPLS};

  agc_cdu_pulse_sync u_sync [1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pin),
    .evt   (evt)
  );

  assign inc = evt[0];
  assign dec = evt[1];

  // ---------------- zero sequencer ----------------
  // state and period count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: a zero request always restarts the full sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (zero_req) begin
      state_d = ZERO;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ZERO: if (ph) begin
          if (cnt_q == ZERO_LAST) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SETTLE: if (ph) begin
          if (cnt_q == SETL_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // decoded from the state register, so reset clears them asynchronously
  assign AGCZ = (state_q == ZERO);
  assign busy = (state_q != IDLE);

  // ---------------- angle counter ----------------
  // counts only in IDLE; wrap flags signed overflow across 0x3FFF/0x4000
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle <= '0;
      wrap  <= 1'b0;
    end else if (zero_req) begin
      angle <= '0;
      wrap  <= 1'b0;
    end else if (state_q != IDLE) begin
      angle <= '0;
    end else if (inc && !dec) begin
      angle <= angle + 15'd1;
      if (angle == 15'h3FFF) wrap <= 1'b1;
    end else if (dec && !inc) begin
      angle <= angle - 15'd1;
      if (angle == 15'h4000) wrap <= 1'b1;
    end
  end
endmodule

// File: tb/tb_agc_cdu_interface.sv
`timescale 1ns/1ps
// Directed bench for agc_cdu_interface (shortened zero/settle lengths).
module tb_agc_cdu_interface;
  localparam int DIV = 977;
  localparam int ZP  = 8;
  localparam int SP  = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        zero_req = 1'b0, ca_en = 1'b0, eec_en = 1'b0;
  logic        cdupls = 1'b0, cdumns = 1'b0;
  logic        clockh, agcca, agcz, agceec, busy, wrap;
  logic [14:0] angle;

  int errs = 0, checks = 0;
  int cyc;
  bit inj = 0, mon_quiet = 0, mon_zero = 0, obad = 0, zbad = 0;
  int inj_stop = 0;

  agc_cdu_interface #(.CLK_DIV(DIV), .CLK_HIGH(830), .ZERO_PERIODS(ZP), .SETTLE_PER(SP)) dut (
    .clk(clk), .rst_n(rst_n), .zero_req(zero_req), .ca_en(ca_en), .eec_en(eec_en),
    .CDUPLS(cdupls), .CDUMNS(cdumns), .CLOCKH(clockh), .AGCCA(agcca), .AGCZ(agcz),
    .AGCEEC(agceec), .angle(angle), .busy(busy), .wrap(wrap)
  );

  always #10 clk = ~clk;

  // edges since reset release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  // background watchers
  always @(negedge clk) begin
    if (mon_quiet && (agcca || agcz || agceec || busy || wrap || angle != 15'd0)) obad = 1;
    if (mon_zero && angle != 15'd0) zbad = 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // wait for a watched output to reach lvl; t = cyc at that negedge, -1 on timeout
  task automatic wait_level(input int which, input logic lvl, input int maxc, output int t);
    logic s;
    t = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (inj) cdupls = (cyc < inj_stop) ? cyc[1] : 1'b0;
      case (which)
        0: s = clockh;
        1: s = agcz;
        2: s = busy;
        3: s = agcca;
        default: s = agceec;
      endcase
      if (s === lvl) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic pulse(input bit p, input bit m, input int hi, input int lo);
    @(negedge clk);
    cdupls = p; cdumns = m;
    repeat (hi) @(negedge clk);
    cdupls = 0; cdumns = 0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    int t, t2, t3, k0, ez, eb;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clockh", clockh, 0);
    chk("rst_angle", angle, 0);
    chk("rst_busy", busy, 0);
    #2 rst_n = 1;
    mon_quiet = 1;

    // CLOCKH shape and quiet outputs
    wait_level(0, 1'b1, 3000, t);
    chk("clkh_first_rise", t, 148);
    wait_level(0, 1'b0, 3000, t2);
    chk("clkh_high", t2 - t, 830);
    wait_level(0, 1'b1, 3000, t3);
    chk("clkh_period", t3 - t, 977);
    mon_quiet = 0;
    chk("quiet_outputs", obad, 0);

    // discretes follow requests only at period boundaries (cyc now 1125)
    ca_en = 1;
    wait_level(3, 1'b1, 2000, t);
    chk("agcca_rise", t, 1954);
    eec_en = 1;
    wait_level(4, 1'b1, 2000, t);
    chk("agceec_rise", t, 2931);
    repeat (300) @(negedge clk);
    ca_en = 0;
    wait_level(3, 1'b0, 2000, t);
    chk("agcca_fall", t, 3908);

    // 100 plus, 30 minus
    for (int i = 0; i < 100; i++) pulse(1, 0, 10, 40);
    for (int i = 0; i < 30; i++) pulse(0, 1, 10, 40);
    settle();
    chk("count_70", angle, 70);
    chk("count_70_wrap", wrap, 0);

    // run up to the positive limit, then across it
    for (int i = 0; i < 16383 - 70; i++) pulse(1, 0, 1, 1);
    settle();
    chk("max_pos", angle, 15'h3FFF);
    chk("max_pos_wrap", wrap, 0);
    pulse(1, 0, 1, 1);
    settle();
    chk("wrap_up", angle, 15'h4000);
    chk("wrap_up_flag", wrap, 1);
    pulse(0, 1, 1, 1);
    settle();
    chk("wrap_down", angle, 15'h3FFF);
    chk("wrap_sticky", wrap, 1);

    // zero sequence with pulses injected throughout
    @(negedge clk);
    zero_req = 1; k0 = cyc + 1;
    @(negedge clk);
    zero_req = 0;
    chk("zero_agcz", agcz, 1);
    chk("zero_busy", busy, 1);
    chk("zero_angle", angle, 0);
    chk("zero_wrap_clr", wrap, 0);
    ez = (k0 / DIV + 1) * DIV + (ZP - 1) * DIV;
    eb = ez + SP * DIV;
    zbad = 0; mon_zero = 1; inj = 1; inj_stop = eb - 8;
    wait_level(1, 1'b0, (ZP + 2) * DIV, t);
    chk("agcz_fall", t, ez);
    wait_level(2, 1'b0, (SP + 2) * DIV, t);
    chk("busy_fall", t, eb);
    mon_zero = 0; inj = 0; cdupls = 0;
    chk("zero_hold", zbad, 0);
    settle();
    chk("zero_after", angle, 0);
    pulse(1, 0, 1, 1);
    settle();
    chk("count_resumes", angle, 1);

    // restart mid-ZERO extends AGCZ
    @(negedge clk);
    zero_req = 1; k0 = cyc + 1;
    @(negedge clk);
    zero_req = 0;
    t = (k0 / DIV + 1) * DIV + 4 * DIV;
    while (cyc < t) @(negedge clk);
    chk("agcz_mid", agcz, 1);
    zero_req = 1; k0 = cyc + 1;
    @(negedge clk);
    zero_req = 0;
    ez = (k0 / DIV + 1) * DIV + (ZP - 1) * DIV;
    wait_level(1, 1'b0, (ZP + 2) * DIV, t);
    chk("agcz_restart_fall", t, ez);
    wait_level(2, 1'b0, (SP + 2) * DIV, t);
    chk("busy_restart_fall", t, ez + SP * DIV);

    // simultaneous plus/minus cancel
    for (int i = 0; i < 5; i++) pulse(1, 0, 1, 1);
    settle();
    chk("preset_5", angle, 5);
    for (int i = 0; i < 50; i++) pulse(1, 1, 1, 1);
    settle();
    chk("cancel_angle", angle, 5);
    chk("cancel_wrap", wrap, 0);

    // async reset mid-ZERO (ca_en raised so AGCCA is 1 beforehand)
    ca_en = 1;
    wait_level(3, 1'b1, 2 * DIV, t);
    @(negedge clk);
    zero_req = 1;
    @(negedge clk);
    zero_req = 0;
    repeat (20) @(negedge clk);
    chk("pre_rst_agcz", agcz, 1);
    #3 rst_n = 0;
    #1;
    chk("arst_agcz", agcz, 0);
    chk("arst_busy", busy, 0);
    chk("arst_angle", angle, 0);
    chk("arst_agcca", agcca, 0);
    chk("arst_agceec", agceec, 0);
    chk("arst_clockh", clockh, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
